game_state_sequencer: RTL and testbench

// Frame-level game sequencer for Space Invaders. Consumes per-pixel collision flags and pulses

---
 rtl/game_state_sequencer_if.sv | 33 +++
 rtl/game_state_sequencer.sv | 175 +++++++++++++++++
 tb/tb_game_state_sequencer.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/game_state_sequencer_if.sv
// Frame-level game control bus: collision/alien events in, game controls and HUD values out.
interface game_state_sequencer_if #(
  parameter int unsigned SCORE_W = 16,
  parameter int unsigned LEVEL_W = 4
);
  logic               startOfFrame;
  logic               startGame;
  logic               playerHit;
  logic               aliensReachedBorder;
  logic               alienKilled;
  logic               allAliensDead;
  logic [2:0]         gameState;
  logic               gameRunning;
  logic               freezeGame;
  logic               gameOver;
  logic               playerBlink;
  logic               levelStartPulse;
  logic [1:0]         lives;
  logic [LEVEL_W-1:0] level;
  logic [SCORE_W-1:0] score;

  modport master (
    output startOfFrame, startGame, playerHit, aliensReachedBorder, alienKilled, allAliensDead,
    input  gameState, gameRunning, freezeGame, gameOver, playerBlink, levelStartPulse,
           lives, level, score
  );

  modport slave (
    input  startOfFrame, startGame, playerHit, aliensReachedBorder, alienKilled, allAliensDead,
    output gameState, gameRunning, freezeGame, gameOver, playerBlink, levelStartPulse,
           lives, level, score
  );
endinterface

// File: rtl/game_state_sequencer.sv
// Once-per-frame game sequencer: lives, level, score and run/freeze/game-over controls.
module game_state_sequencer #(
  parameter int unsigned START_LIVES   = 3,
  parameter int unsigned INVULN_FRAMES = 60,
  parameter int unsigned CLEAR_FRAMES  = 90,
  parameter int unsigned POINTS        = 10,
  parameter int unsigned SCORE_W       = 16,
  parameter int unsigned LEVEL_W       = 4
) (
  input  logic                  clk,
  input  logic                  resetN,
  game_state_sequencer_if.slave bus
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_PLAY        = 3'd1,
    ST_HIT         = 3'd2,
    ST_LEVEL_CLEAR = 3'd3,
    ST_GAME_OVER   = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [1:0]           lives_q, lives_d;
  logic [LEVEL_W-1:0]   level_q, level_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [CNT_W-1:0]     frame_cnt_q, frame_cnt_d;
  logic                 hit_l_q, hit_l_d;
  logic                 border_l_q, border_l_d;
  logic                 clear_l_q, clear_l_d;
  logic                 level_start_q, level_start_d;
  logic                 running_q, running_d;
  logic                 freeze_q, freeze_d;
  logic                 over_q, over_d;
  logic                 blink_q, blink_d;

  logic                 hit_now, border_now, clear_now;
  logic [SCORE_W:0]     score_sum;
  logic [SCORE_W-1:0]   score_sat;

  // Saturating score increment
  always_comb begin
    score_sum = {1'b0, score_q} + (SCORE_W+1)'(POINTS);
    score_sat = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
  end

  always_comb begin
    state_d       = state_q;
    lives_d       = lives_q;
    level_d       = level_q;
    score_d       = score_q;
    frame_cnt_d   = frame_cnt_q;
    hit_l_d       = hit_l_q;
    border_l_d    = border_l_q;
    clear_l_d     = clear_l_q;
    level_start_d = 1'b0;
    hit_now       = hit_l_q | bus.playerHit;
    border_now    = border_l_q | bus.aliensReachedBorder;
    clear_now     = clear_l_q | bus.allAliensDead;

    case (state_q)
      ST_IDLE, ST_GAME_OVER: begin
        if (bus.startGame) begin
          state_d       = ST_PLAY;
          score_d       = '0;
          lives_d       = 2'(START_LIVES);
          level_d       = '0;
          hit_l_d       = 1'b0;
          border_l_d    = 1'b0;
          clear_l_d     = 1'b0;
          level_start_d = 1'b1;
        end else if (bus.startOfFrame) begin
          hit_l_d    = 1'b0;
          border_l_d = 1'b0;
          clear_l_d  = 1'b0;
        end
      end
      ST_PLAY: begin
        hit_l_d    = hit_now;
        border_l_d = border_now;
        clear_l_d  = clear_now;
        if (bus.alienKilled) score_d = score_sat;
        if (bus.startOfFrame) begin
          hit_l_d    = 1'b0;
          border_l_d = 1'b0;
          clear_l_d  = 1'b0;
          // Border beats hit beats clear; at most one life per frame
          if (border_now) begin
            lives_d = 2'd0;
            state_d = ST_GAME_OVER;
          end else if (hit_now) begin
            if (lives_q == 2'd1) begin
              lives_d = 2'd0;
              state_d = ST_GAME_OVER;
            end else begin
              lives_d     = lives_q - 2'd1;
              frame_cnt_d = CNT_W'(INVULN_FRAMES - 1);
              state_d     = ST_HIT;
            end
          end else if (clear_now) begin
            frame_cnt_d = CNT_W'(CLEAR_FRAMES - 1);
            state_d     = ST_LEVEL_CLEAR;
          end
        end
      end
      ST_HIT, ST_LEVEL_CLEAR: begin
        if (bus.startOfFrame) begin
          hit_l_d    = 1'b0;
          border_l_d = 1'b0;
          clear_l_d  = 1'b0;
          if (frame_cnt_q == '0) begin
            state_d = ST_PLAY;
            if (state_q == ST_LEVEL_CLEAR) begin
              level_d       = (level_q == '1) ? level_q : level_q + LEVEL_W'(1);
              level_start_d = 1'b1;
            end
          end else begin
            frame_cnt_d = frame_cnt_q - CNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    running_d = (state_d == ST_PLAY);
    freeze_d  = (state_d == ST_HIT) || (state_d == ST_LEVEL_CLEAR);
    over_d    = (state_d == ST_GAME_OVER);
    blink_d   = (state_d == ST_HIT) && frame_cnt_d[2];
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q       <= ST_IDLE;
      lives_q       <= 2'(START_LIVES);
      level_q       <= '0;
      score_q       <= '0;
      frame_cnt_q   <= '0;
      hit_l_q       <= 1'b0;
      border_l_q    <= 1'b0;
      clear_l_q     <= 1'b0;
      level_start_q <= 1'b0;
      running_q     <= 1'b0;
      freeze_q      <= 1'b0;
      over_q        <= 1'b0;
      blink_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      lives_q       <= lives_d;
      level_q       <= level_d;
      score_q       <= score_d;
      frame_cnt_q   <= frame_cnt_d;
      hit_l_q       <= hit_l_d;
      border_l_q    <= border_l_d;
      clear_l_q     <= clear_l_d;
      level_start_q <= level_start_d;
      running_q     <= running_d;
      freeze_q      <= freeze_d;
      over_q        <= over_d;
      blink_q       <= blink_d;
    end
  end

  assign bus.gameState       = state_q;
  assign bus.gameRunning     = running_q;
  assign bus.freezeGame      = freeze_q;
  assign bus.gameOver        = over_q;
  assign bus.playerBlink     = blink_q;
  assign bus.levelStartPulse = level_start_q;
  assign bus.lives           = lives_q;
  assign bus.level           = level_q;
  assign bus.score           = score_q;

endmodule

// File: tb/tb_game_state_sequencer.sv
// Directed bench for game_state_sequencer: start, hit/invulnerability, game over, clear, saturation.
module tb_game_state_sequencer;
  logic clk;
  logic resetN;
  int   checks;
  int   errors;

  game_state_sequencer_if #(.SCORE_W(16), .LEVEL_W(4)) bus ();

  game_state_sequencer dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sof_pulse();
    bus.startOfFrame = 1'b1;
    step();
    bus.startOfFrame = 1'b0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      sof_pulse();
      step();
    end
  endtask

  task automatic start_pulse();
    bus.startGame = 1'b1;
    step();
    bus.startGame = 1'b0;
  endtask

  task automatic do_reset();
    bus.startOfFrame = 0; bus.startGame = 0; bus.playerHit = 0;
    bus.aliensReachedBorder = 0; bus.alienKilled = 0; bus.allAliensDead = 0;
    resetN = 1'b0;
    step(); step();
    resetN = 1'b1;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.gameState !== 3'd0 || bus.lives !== 2'd3 || bus.level !== 4'd0 || bus.score !== 16'd0) begin
      errors++;
      $display("FAIL reset_vals state=%0d lives=%0d level=%0d score=%0d exp 0/3/0/0",
               bus.gameState, bus.lives, bus.level, bus.score);
    end
    checks++;
    if ({bus.gameRunning, bus.freezeGame, bus.gameOver, bus.playerBlink, bus.levelStartPulse} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b exp 00000",
               {bus.gameRunning, bus.freezeGame, bus.gameOver, bus.playerBlink, bus.levelStartPulse});
    end
    // collisions in IDLE must not matter
    bus.playerHit = 1; step(); bus.playerHit = 0;
    sof_pulse();
    checks++;
    if (bus.gameState !== 3'd0) begin
      errors++; $display("FAIL idle_ignore state=%0d exp 0", bus.gameState);
    end
  endtask

  task automatic test_start();
    start_pulse();
    checks++;
    if (bus.gameState !== 3'd1 || bus.lives !== 2'd3 || bus.score !== 16'd0 || bus.level !== 4'd0) begin
      errors++;
      $display("FAIL start_vals state=%0d lives=%0d score=%0d level=%0d exp 1/3/0/0",
               bus.gameState, bus.lives, bus.score, bus.level);
    end
    checks++;
    if (bus.levelStartPulse !== 1'b1 || bus.gameRunning !== 1'b1) begin
      errors++; $display("FAIL start_pulse pulse=%0b run=%0b exp 1/1", bus.levelStartPulse, bus.gameRunning);
    end
    step();
    checks++;
    if (bus.levelStartPulse !== 1'b0) begin
      errors++; $display("FAIL start_pulse_len pulse=%0b exp 0", bus.levelStartPulse);
    end
    // startGame ignored while playing
    bus.alienKilled = 1; step(); bus.alienKilled = 0;
    start_pulse();
    checks++;
    if (bus.score !== 16'd10 || bus.levelStartPulse !== 1'b0) begin
      errors++; $display("FAIL start_ignored score=%0d pulse=%0b exp 10/0", bus.score, bus.levelStartPulse);
    end
  endtask

  task automatic test_hit_invuln();
    bus.playerHit = 1;
    for (int i = 0; i < 200; i++) step();
    bus.playerHit = 0;
    step();
    sof_pulse();
    checks++;
    if (bus.lives !== 2'd2 || bus.gameState !== 3'd2 || bus.freezeGame !== 1'b1) begin
      errors++;
      $display("FAIL hit_once lives=%0d state=%0d freeze=%0b exp 2/2/1", bus.lives, bus.gameState, bus.freezeGame);
    end
    for (int k = 0; k < 60; k++) begin
      checks++;
      if (bus.gameState !== 3'd2 || bus.playerBlink !== 1'(((59 - k) >> 2) & 1)) begin
        errors++;
        $display("FAIL hit_blink frame=%0d state=%0d blink=%0b exp 2/%0d", k, bus.gameState,
                 bus.playerBlink, ((59 - k) >> 2) & 1);
      end
      // collisions during HIT are ignored
      if (k == 10) bus.playerHit = 1;
      step();
      bus.playerHit = 0;
      sof_pulse();
    end
    checks++;
    if (bus.gameState !== 3'd1 || bus.lives !== 2'd2 || bus.levelStartPulse !== 1'b0) begin
      errors++;
      $display("FAIL hit_return state=%0d lives=%0d pulse=%0b exp 1/2/0", bus.gameState, bus.lives, bus.levelStartPulse);
    end
  endtask

  task automatic test_three_hits();
    do_reset();
    start_pulse();
    for (int h = 0; h < 3; h++) begin
      bus.playerHit = 1; step(); bus.playerHit = 0;
      step();
      sof_pulse();
      checks++;
      if (bus.lives !== 2'(2 - h)) begin
        errors++; $display("FAIL three_hits_lives hit=%0d lives=%0d exp %0d", h, bus.lives, 2 - h);
      end
      if (h < 2) begin
        frames(60);
        checks++;
        if (bus.gameState !== 3'd1) begin
          errors++; $display("FAIL three_hits_play hit=%0d state=%0d exp 1", h, bus.gameState);
        end
        bus.alienKilled = 1; step(); bus.alienKilled = 0;
      end
    end
    checks++;
    if (bus.gameState !== 3'd4 || bus.gameOver !== 1'b1 || bus.score !== 16'd20) begin
      errors++;
      $display("FAIL game_over state=%0d over=%0b score=%0d exp 4/1/20", bus.gameState, bus.gameOver, bus.score);
    end
    start_pulse();
    checks++;
    if (bus.gameState !== 3'd1 || bus.lives !== 2'd3 || bus.score !== 16'd0 || bus.levelStartPulse !== 1'b1) begin
      errors++;
      $display("FAIL restart state=%0d lives=%0d score=%0d pulse=%0b exp 1/3/0/1",
               bus.gameState, bus.lives, bus.score, bus.levelStartPulse);
    end
    step();
  endtask

  task automatic test_level_clear();
    for (int i = 0; i < 5; i++) begin
      bus.alienKilled = 1; step(); bus.alienKilled = 0; step();
    end
    bus.allAliensDead = 1; step(); bus.allAliensDead = 0;
    step();
    sof_pulse();
    checks++;
    if (bus.score !== 16'd50 || bus.gameState !== 3'd3 || bus.freezeGame !== 1'b1 || bus.gameRunning !== 1'b0) begin
      errors++;
      $display("FAIL clear_enter score=%0d state=%0d freeze=%0b run=%0b exp 50/3/1/0",
               bus.score, bus.gameState, bus.freezeGame, bus.gameRunning);
    end
    for (int i = 0; i < 3; i++) begin
      bus.alienKilled = 1; step(); bus.alienKilled = 0;
    end
    frames(89);
    checks++;
    if (bus.gameState !== 3'd3 || bus.score !== 16'd50 || bus.level !== 4'd0) begin
      errors++;
      $display("FAIL clear_hold state=%0d score=%0d level=%0d exp 3/50/0", bus.gameState, bus.score, bus.level);
    end
    sof_pulse();
    checks++;
    if (bus.gameState !== 3'd1 || bus.level !== 4'd1 || bus.levelStartPulse !== 1'b1) begin
      errors++;
      $display("FAIL clear_exit state=%0d level=%0d pulse=%0b exp 1/1/1", bus.gameState, bus.level, bus.levelStartPulse);
    end
    step();
    checks++;
    if (bus.levelStartPulse !== 1'b0 || bus.score !== 16'd50) begin
      errors++; $display("FAIL clear_after pulse=%0b score=%0d exp 0/50", bus.levelStartPulse, bus.score);
    end
  endtask

  task automatic test_border_priority();
    bus.playerHit = 1; bus.aliensReachedBorder = 1; step();
    bus.playerHit = 0; bus.aliensReachedBorder = 0;
    step();
    // kill coincident with the exit decision still scores
    bus.alienKilled = 1;
    sof_pulse();
    bus.alienKilled = 0;
    checks++;
    if (bus.gameState !== 3'd4 || bus.lives !== 2'd0 || bus.score !== 16'd60 || bus.gameOver !== 1'b1) begin
      errors++;
      $display("FAIL border_prio state=%0d lives=%0d score=%0d over=%0b exp 4/0/60/1",
               bus.gameState, bus.lives, bus.score, bus.gameOver);
    end
    step();
    bus.startGame = 1; bus.startOfFrame = 1; step();
    bus.startGame = 0; bus.startOfFrame = 0;
    checks++;
    if (bus.gameState !== 3'd1 || bus.lives !== 2'd3 || bus.level !== 4'd0 || bus.score !== 16'd0) begin
      errors++;
      $display("FAIL start_vs_sof state=%0d lives=%0d level=%0d score=%0d exp 1/3/0/0",
               bus.gameState, bus.lives, bus.level, bus.score);
    end
    step();
  endtask

  task automatic test_saturation_async_reset();
    bus.alienKilled = 1;
    for (int i = 0; i < 6553; i++) step();
    bus.alienKilled = 0;
    checks++;
    if (bus.score !== 16'd65530) begin
      errors++; $display("FAIL score_6553 score=%0d exp 65530", bus.score);
    end
    bus.alienKilled = 1; step();
    checks++;
    if (bus.score !== 16'd65535) begin
      errors++; $display("FAIL score_sat score=%0d exp 65535", bus.score);
    end
    step(); step();
    bus.alienKilled = 0;
    checks++;
    if (bus.score !== 16'd65535) begin
      errors++; $display("FAIL score_sat_hold score=%0d exp 65535", bus.score);
    end
    bus.playerHit = 1; step(); bus.playerHit = 0;
    sof_pulse();
    frames(2);
    checks++;
    if (bus.gameState !== 3'd2 || bus.lives !== 2'd2) begin
      errors++; $display("FAIL pre_reset_hit state=%0d lives=%0d exp 2/2", bus.gameState, bus.lives);
    end
    #2 resetN = 1'b0;
    #1;
    checks++;
    if (bus.gameState !== 3'd0 || bus.lives !== 2'd3 || bus.score !== 16'd0 || bus.level !== 4'd0 ||
        {bus.gameRunning, bus.freezeGame, bus.gameOver, bus.playerBlink, bus.levelStartPulse} !== 5'b0) begin
      errors++;
      $display("FAIL async_reset state=%0d lives=%0d score=%0d level=%0d ctrl=%b exp 0/3/0/0/00000",
               bus.gameState, bus.lives, bus.score, bus.level,
               {bus.gameRunning, bus.freezeGame, bus.gameOver, bus.playerBlink, bus.levelStartPulse});
    end
    step();
    resetN = 1'b1;
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    resetN = 1'b0;
    test_reset();
    test_start();
    test_hit_invuln();
    test_three_hits();
    test_level_clear();
    test_border_priority();
    test_saturation_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
